rf_port_arbiter: RTL

- Shares the 32-entry, 1-write/2-read register file among NREQ requesters.
- Each cycle it issues up to one write and two reads, never presenting an address combination that the register file flags as a collision. Such combinations are deferred instead.
- Round-robin fairness across requesters.
- Read data is routed back to the requester that issued the read, one cycle after the grant.

---
 rtl/rf_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rf_port_arbiter.sv
// Shares a 1-write/2-read register file among NREQ requesters with round-robin
// priority, deferring same-address combinations and routing read data back by tag.
module rf_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [NREQ*DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0]      rf_din,
  output logic [ADDR_WIDTH-1:0]      rf_wad,
  output logic [ADDR_WIDTH-1:0]      rf_rad1,
  output logic [ADDR_WIDTH-1:0]      rf_rad2,
  output logic                       rf_wen,
  output logic                       rf_ren1,
  output logic                       rf_ren2,
  input  logic [DATA_WIDTH-1:0]      rf_dout1,
  input  logic [DATA_WIDTH-1:0]      rf_dout2,
  input  logic                       rf_collision,
  output logic [15:0]                conflict_cnt,
  output logic                       rf_err
);

  localparam int          PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]            pend_q, pend_d;
  logic [NREQ-1:0]            slot_q, slot_d;
  logic [NREQ*DATA_WIDTH-1:0] hold_q, hold_d;
  logic [15:0]                conflict_cnt_q, conflict_cnt_d;
  logic                       rf_err_q, rf_err_d;

  logic                  w_used;
  logic [1:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr1, r_addr2;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  conflict;
  logic                  any_grant;
  logic [PW-1:0]         last_grant;
  logic [NREQ-1:0]       grant;

  // Single scan in priority order; each accepted request narrows what later ones may use.
  always_comb begin
    int unsigned           idx;
    logic [ADDR_WIDTH-1:0] a;
    grant      = '0;
    w_used     = 1'b0;
    r_cnt      = 2'd0;
    w_addr     = '0;
    w_data     = '0;
    r_addr1    = '0;
    r_addr2    = '0;
    conflict   = 1'b0;
    any_grant  = 1'b0;
    last_grant = rr_ptr_q;
    pend_d     = '0;
    slot_d     = '0;
    idx        = 0;
    a          = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ_U;
      a   = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
      if (req_valid[idx] && !reset) begin
        if (req_write[idx]) begin
          if (!w_used) begin
            if ((r_cnt != 2'd0 && a == r_addr1) || (r_cnt == 2'd2 && a == r_addr2)) begin
              conflict = 1'b1;
            end else begin
              grant[idx] = 1'b1;
              w_used     = 1'b1;
              w_addr     = a;
              w_data     = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
              any_grant  = 1'b1;
              last_grant = PW'(idx);
            end
          end
        end else if (r_cnt != 2'd2) begin
          if ((w_used && a == w_addr) || (r_cnt == 2'd1 && a == r_addr1)) begin
            conflict = 1'b1;
          end else begin
            grant[idx]  = 1'b1;
            pend_d[idx] = 1'b1;
            any_grant   = 1'b1;
            last_grant  = PW'(idx);
            if (r_cnt == 2'd0) begin
              r_addr1 = a;
            end else begin
              r_addr2     = a;
              slot_d[idx] = 1'b1;
            end
            r_cnt = r_cnt + 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d       = any_grant ? PW'((32'(last_grant) + 1) % NREQ_U) : rr_ptr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    rf_err_d = rf_err_q | rf_collision;
  end

  // A response tag outstanding when reset arrives is suppressed immediately.
  always_comb begin
    rsp_valid = pend_q & {NREQ{~reset}};
    rsp_data  = hold_q;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (rsp_valid[i]) begin
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i] ? rf_dout2 : rf_dout1;
      end
    end
    hold_d = rsp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      pend_q         <= '0;
      slot_q         <= '0;
      hold_q         <= '0;
      conflict_cnt_q <= '0;
      rf_err_q       <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      pend_q         <= pend_d;
      slot_q         <= slot_d;
      hold_q         <= hold_d;
      conflict_cnt_q <= conflict_cnt_d;
      rf_err_q       <= rf_err_d;
    end
  end

  assign req_ready    = grant;
  assign rf_wen       = w_used;
  assign rf_wad       = w_addr;
  assign rf_din       = w_data;
  assign rf_ren1      = (r_cnt != 2'd0);
  assign rf_ren2      = (r_cnt == 2'd2);
  assign rf_rad1      = r_addr1;
  assign rf_rad2      = r_addr2;
  assign conflict_cnt = conflict_cnt_q;
  assign rf_err       = rf_err_q;

endmodule
